memory_access_stage: RTL and testbench
======================================

Name: memory_access_stage

Overview:
Consumer end of the execute-stage output bundle. Takes the control word, ALU result, store data and compare flag from the execute stage, and performs the load/store on the data memory over a req/gnt/rvalid handshake. Presents aligned, sign- or zero-extended write-back data to the write-back stage. Sits between execute and write-back and stalls execute through ex_ready.

Parameters:
ADDR_WIDTH, 32, width of dmem_addr (low bits of alu_data)
RSP_TIMEOUT, 64, max cycles spent in WAIT_RSP before the access is aborted

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ex_valid  in  1  execute bundle valid
ex_ready  out  1  stage can accept the bundle
control_in  in  control_type  control word from execute
alu_data  in  32  address for memory ops, result otherwise
memory_data  in  32  store data
compflg_in  in  1  compare flag, passed through
dmem_req  out  1  memory request
dmem_we  out  1  1 = store
dmem_addr  out  ADDR_WIDTH  word-aligned address ({alu_data[ADDR_WIDTH-1:2],2'b00})
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  load data valid
dmem_rdata  in  32  load data
wb_valid  out  1  one-cycle write-back pulse
control_out  out  control_type  registered control word
wb_data  out  32  load result, or alu_data for non-memory ops
compflg_out  out  1  registered compflg_in
access_err  out  1  misaligned or illegal size; qualifies wb_valid
timeout_err  out  1  response timeout; qualifies wb_valid

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, timeout counter=0.
  - All outputs 0: ex_ready reads 1 combinationally once in IDLE.
  - An in-flight request is dropped; any late gnt/rvalid is ignored.
- States: IDLE, REQ, WAIT_RSP. ex_ready = (state==IDLE).
- IDLE, ex_valid=1, no mem_read/mem_write:
  - Next cycle: wb_valid=1, wb_data=alu_data, control_out/compflg_out registered.
  - Latency 1. Back-to-back bundles are accepted every cycle.
- IDLE, memory op:
  - Size decode on control_in.mem_size: 000 B, 001 H, 010 W, 100 BU, 101 HU. BU/HU are legal for loads only.
  - Misaligned (H with addr[0]=1, W with addr[1:0]!=0) or illegal size: no request is issued. Next cycle wb_valid=1 and access_err=1, with control_out.reg_write forced to 0.
  - Otherwise latch the bundle and go to REQ.
- REQ:
  - dmem_req=1. addr/we/be/wdata are held stable until dmem_gnt.
  - Store: be = B: 4'b0001<<addr[1:0]; H: 4'b0011<<{addr[1],1'b0}; W: 4'b1111. wdata replicates the byte/half across lanes.
  - Store on gnt: go to IDLE; wb_valid pulses the next cycle with reg_write as given.
  - Load on gnt: go to WAIT_RSP. If dmem_rvalid is also asserted in the gnt cycle, treat it as the response immediately.
- WAIT_RSP:
  - dmem_req=0; the counter increments each cycle.
  - On dmem_rvalid: extract the lane selected by addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU). W passes through.
  - Next cycle wb_valid=1 with wb_data=result; go to IDLE.
  - Counter reaches RSP_TIMEOUT-1 without rvalid: next cycle wb_valid=1, timeout_err=1, reg_write forced to 0; go to IDLE.
- dmem_gnt/dmem_rvalid outside their waiting state are ignored.
- Error flags are 1-cycle pulses aligned with wb_valid; otherwise 0.
- wb_data, control_out and compflg_out hold their last value between pulses.

Decomposition:
- Package common holds:
  - control_type, with fields mem_read, mem_write, mem_size[2:0], reg_write.
  - funct3 size constants (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU).
  - mem_state_t enum {IDLE, REQ, WAIT_RSP}.
- Sub-module lsu_data_align (combinational): computes be/wdata for stores, and lane extract plus sign/zero extension for loads. Instantiated once.

Test Plan:
- ALU pass-through: ex_valid for 3 consecutive cycles with alu_data=0x11,0x22,0x33, no mem op -> wb_valid on 3 consecutive cycles, wb_data 0x11,0x22,0x33, ex_ready stays 1.
- SB: addr=0x103, data=0x000000A5, gnt after 2 cycles -> dmem_addr=0x100, be=4'b1000, wdata=0xA5A5A5A5 held stable until gnt; wb_valid 1 cycle after gnt.
- LB vs LBU: addr=0x202, rdata=0x00800000 -> LB wb_data=0xFFFFFF80; LBU wb_data=0x00000080.
- LH misaligned: addr=0x301 -> no dmem_req; next cycle wb_valid=1, access_err=1, control_out.reg_write=0.
- Timeout: LW, gnt given, rvalid never comes, RSP_TIMEOUT=4 -> wb_valid with timeout_err=1 exactly 4 cycles after the gnt cycle; a later stray rvalid is ignored.
- Reset mid-REQ: rst_n=0 during REQ -> dmem_req=0 and wb_valid=0 the next cycle; state IDLE, ex_ready=1 after release.

Source files
------------

// File: rtl/memory_access_stage_pkg.sv
// rtl/memory_access_stage_pkg.sv - shared types and size decode for the memory access stage
package memory_access_stage_pkg;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_size;
        logic       reg_write;
    } control_type;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} mem_state_t;

    // A bundle with mem_write set is treated as a store even if mem_read is also set.
    function automatic logic access_ok(input control_type c, input logic [1:0] off);
        logic ok;
        case (c.mem_size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = ~off[0];
            SZ_W:    ok = (off == 2'b00);
            SZ_BU:   ok = ~c.mem_write;
            SZ_HU:   ok = ~c.mem_write & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/memory_access_stage_lsu_data_align.sv
// rtl/memory_access_stage_lsu_data_align.sv - store lane replication and load lane extract/extend
module lsu_data_align
    import memory_access_stage_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_result
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (size)
            SZ_B, SZ_BU: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            SZ_H, SZ_HU: begin
                be    = 4'b0011 << {offset[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    assign byte_shift = load_data >> {offset, 3'b000};
    assign half_shift = load_data >> {offset[1], 4'b0000};

    always_comb begin
        load_result = load_data;
        case (size)
            SZ_B:    load_result = {{24{byte_shift[7]}}, byte_shift[7:0]};
            SZ_BU:   load_result = {24'h000000, byte_shift[7:0]};
            SZ_H:    load_result = {{16{half_shift[15]}}, half_shift[15:0]};
            SZ_HU:   load_result = {16'h0000, half_shift[15:0]};
            default: load_result = load_data;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - load/store stage between execute and write-back
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int RSP_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  control_type           control_in,
    input  logic [31:0]           alu_data,
    input  logic [31:0]           memory_data,
    input  logic                  compflg_in,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [31:0]           dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [31:0]           dmem_rdata,
    output logic                  wb_valid,
    output control_type           control_out,
    output logic [31:0]           wb_data,
    output logic                  compflg_out,
    output logic                  access_err,
    output logic                  timeout_err
);

    localparam int TW = $clog2(RSP_TIMEOUT + 1);

    mem_state_t            state;
    logic [TW-1:0]         timer;
    control_type           ctrl_q;
    logic                  cflg_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           sdata_q;
    control_type           ctrl_in_nowr;
    control_type           ctrl_q_nowr;
    logic                  in_is_mem;
    logic                  in_ok;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [31:0]           load_result;

    lsu_data_align u_align (
        .size        (ctrl_q.mem_size),
        .offset      (addr_q[1:0]),
        .store_data  (sdata_q),
        .load_data   (dmem_rdata),
        .be          (be),
        .wdata       (wdata),
        .load_result (load_result)
    );

    always_comb begin
        ctrl_in_nowr           = control_in;
        ctrl_in_nowr.reg_write = 1'b0;
        ctrl_q_nowr            = ctrl_q;
        ctrl_q_nowr.reg_write  = 1'b0;
    end

    assign in_is_mem  = control_in.mem_read | control_in.mem_write;
    assign in_ok      = access_ok(control_in, alu_data[1:0]);

    assign ex_ready   = (state == IDLE);
    assign dmem_req   = (state == REQ);
    assign dmem_we    = dmem_req & ctrl_q.mem_write;
    assign dmem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign dmem_be    = dmem_req ? be : 4'b0000;
    assign dmem_wdata = dmem_we ? wdata : 32'h0;

    // The grant cycle counts as the first cycle of the response window, so the timer starts at 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            ctrl_q      <= '0;
            cflg_q      <= 1'b0;
            addr_q      <= '0;
            sdata_q     <= '0;
            wb_valid    <= 1'b0;
            control_out <= '0;
            wb_data     <= '0;
            compflg_out <= 1'b0;
            access_err  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            wb_valid    <= 1'b0;
            access_err  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (!in_is_mem) begin
                            wb_valid    <= 1'b1;
                            wb_data     <= alu_data;
                            control_out <= control_in;
                            compflg_out <= compflg_in;
                        end else if (!in_ok) begin
                            wb_valid    <= 1'b1;
                            access_err  <= 1'b1;
                            control_out <= ctrl_in_nowr;
                            compflg_out <= compflg_in;
                        end else begin
                            ctrl_q  <= control_in;
                            cflg_q  <= compflg_in;
                            addr_q  <= alu_data[ADDR_WIDTH-1:0];
                            sdata_q <= memory_data;
                            state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        if (ctrl_q.mem_write || dmem_rvalid) begin
                            wb_valid    <= 1'b1;
                            control_out <= ctrl_q;
                            compflg_out <= cflg_q;
                            if (!ctrl_q.mem_write) begin
                                wb_data <= load_result;
                            end
                            state <= IDLE;
                        end else begin
                            timer <= TW'(1);
                            state <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (dmem_rvalid) begin
                        wb_valid    <= 1'b1;
                        wb_data     <= load_result;
                        control_out <= ctrl_q;
                        compflg_out <= cflg_q;
                        timer       <= '0;
                        state       <= IDLE;
                    end else if (timer >= TW'(RSP_TIMEOUT - 1)) begin
                        wb_valid    <= 1'b1;
                        timeout_err <= 1'b1;
                        control_out <= ctrl_q_nowr;
                        compflg_out <= cflg_q;
                        timer       <= '0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - randomized model-checked bench for memory_access_stage
module tb_memory_access_stage;
    import memory_access_stage_pkg::*;

    localparam int RSP_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    control_type control_in = '0;
    logic [31:0] alu_data = '0;
    logic [31:0] memory_data = '0;
    logic        compflg_in = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid;
    control_type control_out;
    logic [31:0] wb_data;
    logic        compflg_out;
    logic        access_err;
    logic        timeout_err;

    always #5 clk = ~clk;

    memory_access_stage #(.ADDR_WIDTH(32), .RSP_TIMEOUT(RSP_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .control_in(control_in), .alu_data(alu_data), .memory_data(memory_data),
        .compflg_in(compflg_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .control_out(control_out), .wb_data(wb_data),
        .compflg_out(compflg_out), .access_err(access_err), .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        chk_data;
        control_type ctrl;
        logic        cflg;
        logic        aerr;
        logic        terr;
        int          due;
    } exp_t;

    exp_t        expq[$];
    exp_t        cur;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] last_wb;
    logic        last_aerr;
    logic        last_terr;
    logic        last_rw;
    logic [31:0] first_addr;
    logic [3:0]  first_be;
    logic [31:0] first_wd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic legal(input control_type c, input logic [31:0] a);
        case (c.mem_size)
            SZ_B:    return 1'b1;
            SZ_H:    return (a % 2) == 0;
            SZ_W:    return (a % 4) == 0;
            SZ_BU:   return !c.mem_write;
            SZ_HU:   return !c.mem_write && (a % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * (a % 4))) & 32'hFF;
        h = (rd >> (8 * (a & 2))) & 32'hFFFF;
        case (sz)
            SZ_B:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            SZ_BU:   return b;
            SZ_H:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            SZ_HU:   return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] sz, input logic [31:0] a);
        if (sz == SZ_B) return 4'(1 << (a % 4));
        if (sz == SZ_H) return 4'(3 << (a & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] store_wd(input logic [2:0] sz, input logic [31:0] d);
        if (sz == SZ_B) return (d & 32'hFF) * 32'h01010101;
        if (sz == SZ_H) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic exp_t model(input control_type c, input logic [31:0] a, input logic [31:0] rd,
                                   input logic cf, input bit tmo);
        exp_t e;
        e.data = '0; e.chk_data = 1'b0; e.ctrl = c; e.cflg = cf;
        e.aerr = 1'b0; e.terr = 1'b0; e.due = -1;
        if (!c.mem_read && !c.mem_write) begin
            e.data = a; e.chk_data = 1'b1;
        end else if (!legal(c, a)) begin
            e.aerr = 1'b1; e.ctrl.reg_write = 1'b0;
        end else if (!c.mem_write) begin
            if (tmo) begin
                e.terr = 1'b1; e.ctrl.reg_write = 1'b0;
            end else begin
                e.data = load_value(c.mem_size, a, rd); e.chk_data = 1'b1;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (wb_valid) begin
                last_wb = wb_data; last_aerr = access_err;
                last_terr = timeout_err; last_rw = control_out.reg_write;
                if (expq.size() == 0) begin
                    check("unexpected_wb_valid", 32'(wb_valid), 32'h0);
                end else begin
                    cur = expq.pop_front();
                    if (cur.due >= 0) check("wb_latency_cycle", cyc, cur.due);
                    check("access_err", 32'(access_err), 32'(cur.aerr));
                    check("timeout_err", 32'(timeout_err), 32'(cur.terr));
                    check("control_out", 32'(control_out), 32'(cur.ctrl));
                    check("compflg_out", 32'(compflg_out), 32'(cur.cflg));
                    if (cur.chk_data) check("wb_data", wb_data, cur.data);
                end
            end else if (access_err || timeout_err) begin
                check("err_without_wb", {access_err, timeout_err}, 32'h0);
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() > 0 && n < RSP_TIMEOUT + 12) begin
            @(posedge clk); #1; n++;
        end
        if (expq.size() > 0) begin
            check("wb_never_arrived", expq.size(), 0);
            expq.delete();
        end
    endtask

    // rdly: 0 = rvalid with gnt, 1..RSP_TIMEOUT-1 = cycles after gnt, >=RSP_TIMEOUT = no response
    task automatic do_op(input control_type c, input logic [31:0] a, input logic [31:0] sd, input logic cf,
                         input logic [31:0] rd, input int gdly, input int rdly);
        exp_t e;
        bit   tmo;
        bit   is_mem;
        bit   bad;
        int   n;
        int   g;
        tmo    = (rdly >= RSP_TIMEOUT);
        is_mem = c.mem_read || c.mem_write;
        n = 0;
        while (!ex_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!ex_ready) check("ex_ready_wait", 32'(ex_ready), 32'h1);
        e = model(c, a, rd, cf, tmo);
        g = cyc + 1 + gdly;
        if (!is_mem || e.aerr) e.due = cyc + 1;
        else if (c.mem_write) e.due = g + 1;
        else if (tmo) e.due = g + RSP_TIMEOUT;
        else e.due = g + rdly + 1;
        expq.push_back(e);
        ex_valid = 1'b1; control_in = c; alu_data = a; memory_data = sd; compflg_in = cf;
        @(posedge clk); #1;
        ex_valid = 1'b0; control_in = control_type'(6'($urandom));
        alu_data = $urandom; memory_data = $urandom; compflg_in = 1'($urandom);
        if (!is_mem || e.aerr) begin
            check("no_dmem_req", 32'(dmem_req), 32'h0);
            drain();
            return;
        end
        bad = 1'b0;
        for (int i = 0; i <= gdly; i++) begin
            if (i == 0) begin first_addr = dmem_addr; first_be = dmem_be; first_wd = dmem_wdata; end
            if (dmem_req !== 1'b1 || ex_ready !== 1'b0 || dmem_addr !== (a & 32'hFFFFFFFC)
                || dmem_we !== c.mem_write) bad = 1'b1;
            if (c.mem_write && (dmem_be !== store_be(c.mem_size, a)
                || dmem_wdata !== store_wd(c.mem_size, sd))) bad = 1'b1;
            if (i < gdly) begin @(posedge clk); #1; end
        end
        check("req_phase_stable", 32'(bad), 32'h0);
        dmem_gnt = 1'b1;
        if (c.mem_read && !c.mem_write && rdly == 0) begin dmem_rvalid = 1'b1; dmem_rdata = rd; end
        else dmem_rdata = $urandom;
        @(posedge clk); #1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        if (c.mem_read && !c.mem_write && rdly > 0) begin
            check("req_dropped_after_gnt", 32'(dmem_req), 32'h0);
            if (!tmo) begin
                repeat (rdly - 1) begin @(posedge clk); #1; end
                dmem_rvalid = 1'b1; dmem_rdata = rd;
                @(posedge clk); #1;
                dmem_rvalid = 1'b0; dmem_rdata = $urandom;
            end
        end
        drain();
        if (tmo && !c.mem_write) begin
            dmem_rvalid = 1'b1;
            @(posedge clk); #1;
            dmem_rvalid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    function automatic control_type mk(input bit rd, input bit wr, input logic [2:0] sz, input bit rw);
        control_type c;
        c.mem_read = rd; c.mem_write = wr; c.mem_size = sz; c.reg_write = rw;
        return c;
    endfunction

    initial begin
        logic [2:0]  szl [8];
        control_type c;
        logic [31:0] a;
        int          kind;
        int          idx;
        szl = '{SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU, 3'b011, 3'b110, 3'b111};

        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs_zero", {wb_valid, dmem_req, dmem_we, access_err, timeout_err, compflg_out,
                                   control_out, dmem_be}, 32'h0);
        check("rst_data_zero", wb_data | dmem_addr | dmem_wdata, 32'h0);
        check("rst_ex_ready", 32'(ex_ready), 32'h1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) begin
            cur = model(mk(0, 0, SZ_W, 1), 32'h11 * (i + 1), 0, i[0], 0);
            cur.due = cyc + 1;
            expq.push_back(cur);
            check("b2b_ex_ready", 32'(ex_ready), 32'h1);
            ex_valid = 1'b1; control_in = mk(0, 0, SZ_W, 1); alu_data = 32'h11 * (i + 1); compflg_in = i[0];
            @(posedge clk); #1;
        end
        ex_valid = 1'b0;
        check("b2b_ex_ready_after", 32'(ex_ready), 32'h1);
        drain();
        check("b2b_last_literal", last_wb, 32'h33);

        do_op(mk(0, 1, SZ_B, 0), 32'h103, 32'h000000A5, 1'b0, 0, 2, 0);
        check("sb_addr_literal", first_addr, 32'h100);
        check("sb_be_literal", 32'(first_be), 32'h8);
        check("sb_wdata_literal", first_wd, 32'hA5A5A5A5);

        do_op(mk(1, 0, SZ_B, 1), 32'h202, 0, 1'b1, 32'h00800000, 1, 1);
        check("lb_literal", last_wb, 32'hFFFFFF80);
        do_op(mk(1, 0, SZ_BU, 1), 32'h202, 0, 1'b0, 32'h00800000, 0, 0);
        check("lbu_literal", last_wb, 32'h00000080);

        do_op(mk(1, 0, SZ_H, 1), 32'h301, 0, 1'b0, 0, 0, 0);
        check("lh_mis_access_err", 32'(last_aerr), 32'h1);
        check("lh_mis_reg_write", 32'(last_rw), 32'h0);

        do_op(mk(1, 0, SZ_W, 1), 32'h400, 0, 1'b1, 0, 1, RSP_TIMEOUT);
        check("timeout_err_literal", 32'(last_terr), 32'h1);

        do_op(mk(1, 0, SZ_W, 1), 32'h500, 0, 1'b0, 32'hCAFEF00D, 0, RSP_TIMEOUT - 1);
        check("lw_last_window_literal", last_wb, 32'hCAFEF00D);

        ex_valid = 1'b1; control_in = mk(1, 0, SZ_W, 1); alu_data = 32'h600;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        check("rst_mid_req_in_req", 32'(dmem_req), 32'h1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_req_outputs", {dmem_req, wb_valid}, 32'h0);
        rst_n = 1'b1;
        check("rst_mid_req_ready", 32'(ex_ready), 32'h1);
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        check("late_rsp_ignored", {dmem_req, wb_valid}, 32'h0);

        for (int t = 0; t < 200; t++) begin
            kind = $urandom_range(0, 2);
            idx = $urandom_range(0, 10);
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            c = mk(kind == 1, kind == 2, szl[idx > 7 ? 2 : idx], 1'($urandom));
            do_op(c, a, $urandom, 1'($urandom), $urandom, $urandom_range(0, 3),
                  $urandom_range(0, RSP_TIMEOUT));
            repeat ($urandom_range(0, 2)) begin
                dmem_gnt = 1'($urandom); dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
                @(posedge clk); #1;
                if (dmem_req) check("idle_stray_req", 32'(dmem_req), 32'h0);
            end
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        end

        repeat (4) begin @(posedge clk); #1; end
        check("queue_empty_end", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
